// File: rtl/fpu_float_mult_iterative.sv
// Sequential single-precision float multiplier: shift-and-add mantissa product,
// one-cycle normalise, one-cycle round, valid/ready on both sides, one op in flight.
module fpu_float_mult_iterative #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [1:0]  in_round_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_inexact
);

    localparam int ITERS = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] ITERS_CNT = 5'(ITERS);

    typedef enum logic [1:0] {
        RM_EVEN = 2'd0,
        RM_DOWN = 2'd1,
        RM_UP   = 2'd2,
        RM_ZERO = 2'd3
    } fpu_round_mode_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] exponent;
        logic [22:0] mantissa;
    } fpu_float_fields_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    fpu_float_fields_t a_reg, b_reg;
    fpu_round_mode_t   rmode_reg;
    logic [47:0]       acc_reg;
    logic [47:0]       a_shift_reg;
    logic [23:0]       b_shift_reg;
    logic [4:0]        cnt_reg;
    logic signed [9:0] exp_norm_reg;
    logic [22:0]       mant_norm_reg;
    logic              g_reg, r_reg, s_reg;
    logic [31:0]       result_reg;
    logic              inexact_reg;

    fpu_float_fields_t in_a_f, in_b_f;
    logic [23:0]       mant_a_in, mant_b_in;

    // Denormal operands are flushed to zero before entering the datapath.
    always_comb begin
        in_a_f    = fpu_float_fields_t'(in_a);
        in_b_f    = fpu_float_fields_t'(in_b);
        mant_a_in = (in_a_f.exponent == 8'd0) ? 24'd0 : {1'b1, in_a_f.mantissa};
        mant_b_in = (in_b_f.exponent == 8'd0) ? 24'd0 : {1'b1, in_b_f.mantissa};
    end

    // One shifted copy of the multiplicand per multiplier bit consumed this cycle.
    logic [47:0] pp [BITS_PER_CYCLE];
    logic [47:0] partial;

    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
            assign pp[gi] = b_shift_reg[gi] ? (a_shift_reg << gi) : 48'd0;
        end
    endgenerate

    always_comb begin
        partial = 48'd0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            partial = partial + pp[i];
        end
    end

    logic signed [9:0] exp_base;
    always_comb begin
        exp_base = $signed({2'b00, a_reg.exponent}) + $signed({2'b00, b_reg.exponent}) - 10'sd127;
    end

    // Rounding and special-case resolution.
    logic              sign;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              tie_up, round_up;
    logic [23:0]       mant_sum;
    logic signed [9:0] exp_rnd;
    logic [22:0]       mant_fin;
    logic [31:0]       round_result;
    logic              round_inexact;

    always_comb begin
        sign   = a_reg.sign ^ b_reg.sign;
        a_nan  = (a_reg.exponent == 8'hFF) && (a_reg.mantissa != 23'd0);
        b_nan  = (b_reg.exponent == 8'hFF) && (b_reg.mantissa != 23'd0);
        a_inf  = (a_reg.exponent == 8'hFF) && (a_reg.mantissa == 23'd0);
        b_inf  = (b_reg.exponent == 8'hFF) && (b_reg.mantissa == 23'd0);
        a_zero = (a_reg.exponent == 8'd0);
        b_zero = (b_reg.exponent == 8'd0);

        tie_up = 1'b0;
        case (rmode_reg)
            RM_EVEN: tie_up = mant_norm_reg[0];
            RM_DOWN: tie_up = 1'b0;
            RM_UP:   tie_up = 1'b1;
            RM_ZERO: tie_up = sign;
            default: tie_up = 1'b0;
        endcase
        // With R|S set the tie rule never applies, so it folds into one term.
        round_up = g_reg & (r_reg | s_reg | tie_up);

        mant_sum = {1'b0, mant_norm_reg} + {23'd0, round_up};
        exp_rnd  = exp_norm_reg + (mant_sum[23] ? 10'sd1 : 10'sd0);
        mant_fin = mant_sum[23] ? 23'd0 : mant_sum[22:0];

        round_result  = {sign, exp_rnd[7:0], mant_fin};
        round_inexact = g_reg | r_reg | s_reg;
        if (exp_rnd >= 10'sd255) begin
            round_result  = {sign, 8'hFF, 23'd0};
            round_inexact = 1'b1;
        end else if (exp_rnd <= 10'sd0) begin
            round_result  = {sign, 31'd0};
            round_inexact = 1'b1;
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            round_result  = 32'h7FC0_0000;
            round_inexact = 1'b0;
        end else if (a_inf || b_inf) begin
            round_result  = {sign, 8'hFF, 23'd0};
            round_inexact = 1'b0;
        end else if (a_zero || b_zero) begin
            round_result  = {sign, 31'd0};
            round_inexact = 1'b0;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (in_valid) state_next = S_MULT;
            S_MULT:  if (cnt_reg == ITERS_CNT) state_next = S_NORM;
            S_NORM:  state_next = S_ROUND;
            S_ROUND: state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            rmode_reg     <= RM_EVEN;
            acc_reg       <= 48'd0;
            a_shift_reg   <= 48'd0;
            b_shift_reg   <= 24'd0;
            cnt_reg       <= 5'd0;
            exp_norm_reg  <= 10'sd0;
            mant_norm_reg <= 23'd0;
            g_reg         <= 1'b0;
            r_reg         <= 1'b0;
            s_reg         <= 1'b0;
            result_reg    <= 32'd0;
            inexact_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg       <= in_a_f;
                        b_reg       <= in_b_f;
                        rmode_reg   <= fpu_round_mode_t'(in_round_mode);
                        acc_reg     <= 48'd0;
                        a_shift_reg <= {24'd0, mant_a_in};
                        b_shift_reg <= mant_b_in;
                        cnt_reg     <= 5'd0;
                    end
                end
                S_MULT: begin
                    if (cnt_reg != ITERS_CNT) begin
                        acc_reg     <= acc_reg + partial;
                        a_shift_reg <= a_shift_reg << BITS_PER_CYCLE;
                        b_shift_reg <= b_shift_reg >> BITS_PER_CYCLE;
                        cnt_reg     <= cnt_reg + 5'd1;
                    end
                end
                S_NORM: begin
                    if (acc_reg[47]) begin
                        exp_norm_reg  <= exp_base + 10'sd1;
                        mant_norm_reg <= acc_reg[46:24];
                        g_reg         <= acc_reg[23];
                        r_reg         <= acc_reg[22];
                        s_reg         <= |acc_reg[21:0];
                    end else begin
                        exp_norm_reg  <= exp_base;
                        mant_norm_reg <= acc_reg[45:23];
                        g_reg         <= acc_reg[22];
                        r_reg         <= acc_reg[21];
                        s_reg         <= |acc_reg[20:0];
                    end
                end
                S_ROUND: begin
                    result_reg  <= round_result;
                    inexact_reg <= round_inexact;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_reg == S_IDLE);
    assign out_valid   = (state_reg == S_DONE);
    assign out_result  = result_reg;
    assign out_inexact = inexact_reg;

endmodule

// File: tb/tb_fpu_float_mult_iterative.sv
// Scoreboard bench for fpu_float_mult_iterative: directed corner cases plus
// randomized operands checked against an integer-arithmetic reference model.
module tb_fpu_float_mult_iterative;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_inexact;
    logic [31:0] in_a, in_b, out_result;
    logic [1:0]  in_round_mode;

    logic        in8_valid, in8_ready, out8_valid, out8_ready, out8_inexact;
    logic [31:0] in8_a, in8_b, out8_result;
    logic [1:0]  in8_round_mode;

    always #5 clk = ~clk;

    fpu_float_mult_iterative #(.BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_round_mode(in_round_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_inexact(out_inexact)
    );

    fpu_float_mult_iterative #(.BITS_PER_CYCLE(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in8_valid), .in_ready(in8_ready),
        .in_a(in8_a), .in_b(in8_b), .in_round_mode(in8_round_mode),
        .out_valid(out8_valid), .out_ready(out8_ready),
        .out_result(out8_result), .out_inexact(out8_inexact)
    );

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    logic [32:0] exp_q[$];
    int unsigned acc_q[$];
    bit          rnd_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout/none required event (cycle %0d)", name, cyc);
    endtask

    // Reference: exact integer product, normalised by magnitude, rounded from the remainder.
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] rm);
        logic sign;
        int ea, eb, e, sh;
        longint unsigned ma, mb, p, kept, rem, half;
        bit up, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        sign   = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {1'b0, 32'h7FC00000};
        if (a_inf || b_inf) return {1'b0, sign, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {1'b0, sign, 31'd0};
        ma = (64'd1 << 23) + 64'(a[22:0]);
        mb = (64'd1 << 23) + 64'(b[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin sh = 24; e++; end
        else sh = 23;
        kept = p >> sh;
        rem  = p - (kept << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half) up = 1'b1;
        else if (rem == half) begin
            case (rm)
                2'd0: up = kept[0];
                2'd1: up = 1'b0;
                2'd2: up = 1'b1;
                default: up = sign;
            endcase
        end else up = 1'b0;
        kept = kept + 64'(up);
        if (kept == (64'd1 << 24)) begin kept = 64'd1 << 23; e++; end
        if (e >= 255) return {1'b1, sign, 8'hFF, 23'd0};
        if (e <= 0) return {1'b1, sign, 31'd0};
        return {rem != 0, sign, 8'(e), kept[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 19);
        if (k == 0) v[30:23] = 8'd0;
        else if (k == 1) v[30:0] = {8'hFF, 23'd0};
        else if (k == 2) begin v[30:23] = 8'hFF; v[22] = 1'b1; end
        else if (k == 3) v[30:23] = 8'($urandom_range(1, 20));
        else if (k == 4) v[30:23] = 8'($urandom_range(235, 254));
        else if (k == 5) begin
            v[30:23] = 8'($urandom_range(110, 140));
            v[21:2]  = 20'd0;
        end else v[30:23] = 8'($urandom_range(100, 154));
        return v;
    endfunction

    // Always entered at posedge+#1 so no input changes race the negedge monitor.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                         input logic [32:0] e);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        in_a = a; in_b = b; in_round_mode = rm; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 500) begin @(negedge clk); n++; end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        #1;
    endtask

    // Monitor: records accept cycles, checks latency, results and stall stability.
    initial begin
        bit          prev_valid, hold;
        logic [32:0] held, e;
        prev_valid = 1'b0;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_result", 64'({out_inexact, out_result}), 64'(held));
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                end
                if (in_valid && in_ready) acc_q.push_back(cyc + 1);
                if (out_valid && !prev_valid) begin
                    if (acc_q.size() == 0) fail_now("latency_no_accept");
                    else chk("latency", 64'(cyc - acc_q.pop_front()), 64'd27);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_output");
                    else begin
                        e = exp_q.pop_front();
                        chk("result", 64'(out_result), 64'(e[31:0]));
                        chk("inexact", 64'(out_inexact), 64'(e[32]));
                    end
                end
                hold = out_valid && !out_ready;
                held = {out_inexact, out_result};
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    logic [31:0] da[9] = '{32'h7F000000, 32'h00800000, 32'hC0000000, 32'h7F800000,
                          32'h7F800000, 32'h7FC00001, 32'h00400000, 32'h3FC00000, 32'h40400000};
    logic [31:0] db[9] = '{32'h40000000, 32'h00800000, 32'h40400000, 32'h00000000,
                          32'hC0000000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000};
    logic [32:0] dr[9] = '{{1'b1, 32'h7F800000}, {1'b1, 32'h00000000}, {1'b0, 32'hC0C00000},
                          {1'b0, 32'h7FC00000}, {1'b0, 32'hFF800000}, {1'b0, 32'h7FC00000},
                          {1'b0, 32'h00000000}, {1'b0, 32'h40400000}, {1'b0, 32'h41100000}};
    logic [31:0] tie_r[4] = '{32'h3FC00002, 32'h3FC00001, 32'h3FC00002, 32'h3FC00001};

    initial begin
        int n;
        logic [31:0] ra, rb;
        logic [1:0]  rm;
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_round_mode = 2'd0; out_ready = 1'b1;
        in8_valid = 1'b0; in8_a = '0; in8_b = '0; in8_round_mode = 2'd0; out8_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_inexact", 64'(out_inexact), 64'd0);
        rst = 1'b0;

        // Latency of the 8-bits-per-cycle variant.
        @(posedge clk);
        #1;
        in8_a = 32'h3FC00000; in8_b = 32'h40000000; in8_valid = 1'b1;
        @(posedge clk);
        #1;
        in8_valid = 1'b0;
        n = 0;
        while (!out8_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("bpc8_latency", 64'(n), 64'd6);
        chk("bpc8_result", 64'(out8_result), 64'h40400000);
        chk("bpc8_inexact", 64'(out8_inexact), 64'd0);

        for (int i = 0; i < 4; i++) issue(32'h3F800001, 32'h3FC00000, 2'(i), {1'b1, tie_r[i]});
        for (int i = 0; i < 9; i++) issue(da[i], db[i], 2'd0, dr[i]);
        drain();

        // Backpressure: hold the result for 10 cycles, then release.
        out_ready = 1'b0;
        issue(32'h40400000, 32'h40400000, 2'd0, {1'b0, 32'h41100000});
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (!out_valid) fail_now("bp_wait_valid");
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        issue(32'h3F800000, 32'h40A00000, 2'd0, {1'b0, 32'h40A00000});
        drain();

        // Asynchronous reset in the middle of MULT.
        issue(32'h3F800001, 32'h3FC00000, 2'd0, {1'b1, 32'h3FC00002});
        repeat (10) @(posedge clk);
        #1;
        chk("mid_op_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        issue(32'h40000000, 32'h40000000, 2'd0, {1'b0, 32'h40800000});
        drain();

        // Randomized operands with random consumer backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            rm = 2'($urandom_range(0, 3));
            issue(ra, rb, rm, ref_mul(ra, rb, rm));
        end
        drain();
        rnd_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
